ariane_clint_timer: RTL
=======================

# ariane_clint_timer

Multi-hart machine timer and software-interrupt unit (CLINT-style) for the Ariane SoC. It keeps a 64-bit `mtime` that advances on synchronised RTC edges through a programmable prescaler. It also holds one `mtimecmp` and one `msip` bit per hart and raises a registered timer interrupt and software interrupt per hart. It sits on the peripheral bus behind a simple request/response register port and drives `time_o` to all cores.

## Interface
- `NR_HARTS`, default 1: number of harts, i.e. the number of `mtimecmp`/`msip` instances and interrupt lines; valid range 1..32.
- `PRESC_W`, default 8: width of the prescaler divisor field.
- `clk_i` input 1: clock. One clock; all logic is in this domain.
- `rst_ni` input 1: reset. Synchronous, active-low.
- `req_i` input 1: register access request, sampled every cycle; always accepted.
- `we_i` input 1: 1 = write, 0 = read.
- `addr_i` input 16: byte address. Bits [2:0] are ignored, so accesses are 64-bit aligned.
- `be_i` input 8: byte enables for writes.
- `wdata_i` input 64: write data.
- `rvalid_o` output 1: response valid, asserted exactly 1 cycle after each `req_i`, for reads and writes alike.
- `rdata_o` output 64: read data. It is 0 for writes and for unmapped addresses.
- `err_o` output 1: asserted with `rvalid_o` when the address is unmapped.
- `rtc_i` input 1: asynchronous real-time clock (typically 32.768 kHz).
- `time_o` output 64: current `mtime_q`.
- `mtip_o` output NR_HARTS: per-hart timer interrupt.
- `msip_o` output NR_HARTS: per-hart software interrupt.

## Operation
- Register map (byte address):
  - 0x0000 + 8·h: `MSIP[h]`. Only bit 0 is implemented; other bits read 0.
  - 0x4000 + 8·h: `MTIMECMP[h]`.
  - 0xBFF0: `CTRL`. Bit 0 = `EN`; bits [8+PRESC_W-1:8] = `DIV`.
  - 0xBFF8: `MTIME`.
  - Any hart index h ≥ NR_HARTS is unmapped. Every other address is also unmapped.
- Writes:
  - Writes are merged bytewise under `be_i`. Unenabled bytes keep their old value.
  - A write to an unmapped address has no effect and sets `err_o`.
  - A write with `be_i` = 0 to a mapped address is legal and has no effect.
- RTC path:
  - `rtc_i` passes through a 2-flop synchroniser and then a rising-edge detector. This produces a 1-cycle `tick`.
  - A prescaler counter `pc` (PRESC_W bits) advances on `tick` while `EN` = 1.
  - On a `tick` with `pc == DIV`: `pc` is cleared to 0 and `mtime` increments by 1. On any other `tick`: `pc` increments by 1.
  - Net effect: `mtime` advances once every DIV+1 RTC edges.
  - While `EN` = 0, `pc` and `mtime` hold their values.
  - Writing `CTRL` clears `pc` to 0.
- `mtime` arithmetic:
  - 64-bit unsigned; wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
  - If an `MTIME` write with any `be_i` bit set coincides with an increment, the write wins: the merged write value is loaded and that increment is lost.
- Interrupts:
  - `mtip_o[h]` is registered: `mtip_o[h]` ← (`mtime_q` ≥ `mtimecmp_q[h]`), unsigned comparison.
  - `mtip_o[h]` stays asserted until `mtimecmp[h]` is raised above `mtime`, or `mtime` wraps.
  - `msip_o[h]` = `MSIP[h]` bit 0, driven directly from its register.
- Reads:
  - `rdata_o` is registered and returns the register contents before any write in the same cycle.

## Timing
- Reset values:
  - `mtime` = 0, `pc` = 0.
  - `CTRL`: `EN` = 1, `DIV` = 0.
  - `mtimecmp[*]` = all ones. Consequently `mtip_o` = 0, except in the single case `mtime` = all ones.
  - `msip_o` = 0, `mtip_o` = 0, `rvalid_o` = 0, `rdata_o` = 0, `err_o` = 0.
- Reset is synchronous: asserting `rst_ni` low in the middle of an access cancels the pending `rvalid_o`; it reads 0 on the next edge.
- Access latency: request in cycle N → `rvalid_o`, `rdata_o` and `err_o` in cycle N+1. Back-to-back requests give back-to-back responses.
- Write visibility: a write in cycle N updates the register at edge N+1. A read issued in cycle N+1 returns the new value.
- Interrupt latency: `mtip_o` changes 1 cycle after `mtime_q` or `mtimecmp_q` changes. `msip_o` changes at the write edge.
- RTC latency: a rising edge on `rtc_i` increments `mtime_q` 3 `clk_i` edges later (synchroniser, then edge detect, then register).
- RTC frequency limit: `rtc_i` must stay below `clk_i`/4. Faster edges may be lost; this is not checked.

## Test plan
- Reset, then read 0xBFF8 → `rvalid_o` = 1 one cycle later with `rdata_o` = 0. Read 0x4000 → 0xFFFF_FFFF_FFFF_FFFF. `mtip_o` = 0 and `msip_o` = 0.
- `DIV` = 0; apply 5 `rtc_i` rising edges → `mtime` = 5. Write `CTRL` with `DIV` = 3, then apply 8 edges → `mtime` = 7. Write `EN` = 0, then apply 4 edges → `mtime` stays 7.
- NR_HARTS = 4: write `MTIMECMP[2]` = 10 and let `mtime` reach 10 → `mtip_o` = 4'b0100 one cycle after `mtime_q` = 10. Write `MTIMECMP[2]` = 20 → `mtip_o` = 0 one cycle later.
- Write `MTIME` with `be_i` = 0x0F and `wdata_i` = 0x1234_5678_DEAD_BEEF starting from `mtime` = 0xAAAA_AAAA_0000_0000, in the same cycle as a `tick` → `mtime` = 0xAAAA_AAAA_DEAD_BEEF (the tick's increment is lost).
- Write `MTIME` = 0xFFFF_FFFF_FFFF_FFFF, then apply 1 tick → `mtime` = 0 and `mtip_o` follows the comparison with `mtimecmp` for each hart.
- Write `MSIP[1]` = 1 → `msip_o[1]` = 1. Access 0x0010 with NR_HARTS = 2 → `err_o` = 1 and `rdata_o` = 0. Pull `rst_ni` low → all outputs = 0 on the next edge.

Source files
------------

// File: rtl/ariane_clint_timer.sv
// CLINT-style machine timer and software-interrupt unit.
// Holds mtime with an RTC prescaler, plus per-hart mtimecmp and msip registers.
module ariane_clint_timer #(
    parameter int unsigned NR_HARTS = 1,
    parameter int unsigned PRESC_W  = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [15:0]         addr_i,
    input  logic [7:0]          be_i,
    input  logic [63:0]         wdata_i,
    output logic                rvalid_o,
    output logic [63:0]         rdata_o,
    output logic                err_o,
    input  logic                rtc_i,
    output logic [63:0]         time_o,
    output logic [NR_HARTS-1:0] mtip_o,
    output logic [NR_HARTS-1:0] msip_o
);

    localparam logic [12:0] CTRL_IDX  = 13'h17FE;
    localparam logic [12:0] MTIME_IDX = 13'h17FF;

    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] wd,
                                          input logic [7:0]  be);
        logic [63:0] res;
        for (int b = 0; b < 8; b++) begin
            res[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
        end
        return res;
    endfunction

    logic [2:0]         rtc_q;
    logic               tick;
    logic               en_q;
    logic [PRESC_W-1:0] div_q;
    logic [PRESC_W-1:0] pc_q;
    logic [63:0]        mtime_q;
    logic [63:0]        mtimecmp_q [NR_HARTS];
    logic [NR_HARTS-1:0] msip_q;
    logic [NR_HARTS-1:0] mtip_q;
    logic               rvalid_q;
    logic               err_q;
    logic [63:0]        rdata_q;

    logic [12:0]        word;
    logic [10:0]        hidx;
    logic               hart_ok;
    logic               sel_msip;
    logic               sel_cmp;
    logic               sel_ctrl;
    logic               sel_time;
    logic               mapped;
    logic               wr;
    logic [63:0]        rd_val;
    logic               en_d;
    logic [PRESC_W-1:0] div_d;
    logic               inc;
    logic               unused_addr;

    assign unused_addr = ^addr_i[2:0];

    // Bit 2 of the chain is the previous synchronised value for edge detection.
    assign tick = rtc_q[1] & ~rtc_q[2];
    assign inc  = tick & en_q & (pc_q == div_q);

    always_comb begin
        word     = addr_i[15:3];
        hidx     = addr_i[13:3];
        hart_ok  = hidx < 11'(NR_HARTS);
        sel_msip = (addr_i[15:14] == 2'b00) && hart_ok;
        sel_cmp  = (addr_i[15:14] == 2'b01) && hart_ok;
        sel_ctrl = (word == CTRL_IDX);
        sel_time = (word == MTIME_IDX);
        mapped   = sel_msip | sel_cmp | sel_ctrl | sel_time;
        wr       = req_i & we_i & (|be_i);
        rd_val   = '0;
        for (int h = 0; h < NR_HARTS; h++) begin
            if (sel_msip && hidx == 11'(h)) rd_val = {63'b0, msip_q[h]};
            if (sel_cmp && hidx == 11'(h))  rd_val = mtimecmp_q[h];
        end
        if (sel_ctrl) begin
            rd_val[0]            = en_q;
            rd_val[8 +: PRESC_W] = div_q;
        end
        if (sel_time) rd_val = mtime_q;
        en_d  = be_i[0] ? wdata_i[0] : en_q;
        div_d = div_q;
        for (int i = 0; i < PRESC_W; i++) begin
            if (be_i[(8 + i) / 8]) div_d[i] = wdata_i[8 + i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rtc_q   <= '0;
            en_q    <= 1'b1;
            div_q   <= '0;
            pc_q    <= '0;
            mtime_q <= '0;
        end else begin
            rtc_q <= {rtc_q[1:0], rtc_i};
            if (tick && en_q) begin
                pc_q <= inc ? '0 : pc_q + 1'b1;
            end
            if (inc) mtime_q <= mtime_q + 64'd1;
            if (wr && sel_ctrl) begin
                en_q  <= en_d;
                div_q <= div_d;
                pc_q  <= '0;
            end
            // A register write beats a coincident increment.
            if (wr && sel_time) mtime_q <= merge(mtime_q, wdata_i, be_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            msip_q <= '0;
            mtip_q <= '0;
            for (int h = 0; h < NR_HARTS; h++) mtimecmp_q[h] <= '1;
        end else begin
            for (int h = 0; h < NR_HARTS; h++) begin
                mtip_q[h] <= (mtime_q >= mtimecmp_q[h]);
                if (wr && sel_msip && hidx == 11'(h) && be_i[0]) begin
                    msip_q[h] <= wdata_i[0];
                end
                if (wr && sel_cmp && hidx == 11'(h)) begin
                    mtimecmp_q[h] <= merge(mtimecmp_q[h], wdata_i, be_i);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= req_i;
            err_q    <= req_i & ~mapped;
            rdata_q  <= (req_i && !we_i && mapped) ? rd_val : '0;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;
    assign time_o   = mtime_q;
    assign mtip_o   = mtip_q;
    assign msip_o   = msip_q;

endmodule
